// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the canned segment-control patterns
// (advance, freeze, bubble, load-use stall) driven onto the segment registers.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_t;

    // Segment-register controls. Enables are active-low; flushes active-high.
    typedef struct packed {
        logic n_en_pc;
        logic n_en_if_id;
        logic n_en_id_ex;
        logic n_en_ex_mem;
        logic n_en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } seg_ctrl_t;

    // Everything advances, nothing squashed.
    localparam seg_ctrl_t CTRL_ADVANCE  = 7'b00000_00;
    // Whole pipeline holds; also the value presented while in reset.
    localparam seg_ctrl_t CTRL_FREEZE   = 7'b11111_00;
    // Wrong-path squash: IF/ID and ID/EX load bubbles, everything else advances.
    localparam seg_ctrl_t CTRL_BUBBLE   = 7'b00000_11;
    // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
    localparam seg_ctrl_t CTRL_LOAD_USE = 7'b11000_01;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Writes to x0 never create a hazard.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Drives the active-low segment enables and bubble controls combinationally
// from the registered FSM state plus current hazard inputs (Mealy), so every
// hazard is answered in the cycle it appears.
// Optional performance counters: define HAZARD_PERF_CNT_EN to add
// perf_stall_cycles and perf_flush_events.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       n_enable_pc,
    output logic       n_enable_if_id,
    output logic       n_enable_id_ex,
    output logic       n_enable_ex_mem,
    output logic       n_enable_mem_wb,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_events
`endif
);

    // Remaining flush cycles loaded when a redirect starts a multi-cycle flush.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    ctrl_state_t state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    seg_ctrl_t   seg_ctrl;
    logic        load_use;
    logic        flush_start;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Next-state and segment-control decode; priority mem_busy > branch > load-use.
    always_comb begin
        seg_ctrl    = CTRL_ADVANCE;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        flush_start = 1'b0;
        unique case (state_q)
            // MEM_WAIT re-evaluates exactly like RUN once memory is ready; the
            // frozen EX inputs let a held branch or load-use be serviced on exit.
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    seg_ctrl = CTRL_FREEZE;
                    state_d  = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    seg_ctrl    = CTRL_BUBBLE;
                    flush_start = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (load_use) begin
                    seg_ctrl = CTRL_LOAD_USE;
                    state_d  = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            // EX/ID only hold bubbles here, so branch and load-use are ignored.
            FLUSH: begin
                if (mem_busy) begin
                    seg_ctrl = CTRL_FREEZE;
                end else begin
                    seg_ctrl    = CTRL_BUBBLE;
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = 2'd0;
            end
        endcase
        // Reset must present the freeze pattern immediately, not at the next edge.
        if (!n_reset) begin
            seg_ctrl = CTRL_FREEZE;
        end
    end

    // FSM state and flush counter; reset aborts any flush in progress.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign n_enable_pc     = seg_ctrl.n_en_pc;
    assign n_enable_if_id  = seg_ctrl.n_en_if_id;
    assign n_enable_id_ex  = seg_ctrl.n_en_id_ex;
    assign n_enable_ex_mem = seg_ctrl.n_en_ex_mem;
    assign n_enable_mem_wb = seg_ctrl.n_en_mem_wb;
    assign flush_if_id     = seg_ctrl.flush_if_id;
    assign flush_id_ex     = seg_ctrl.flush_id_ex;
    assign ctrl_state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, flush_evt_q;

    // Saturating counters: stalled-PC cycles and serviced taken branches.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
        end else begin
            if (seg_ctrl.n_en_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_start && (flush_evt_q != '1)) begin
                flush_evt_q <= flush_evt_q + CNT_ONE;
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_events = flush_evt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share all
// inputs: dut3 (FLUSH_CYCLES=3) and dut4 (FLUSH_CYCLES=4). Observed vector is
// {ctrl_state, n_en_pc, n_en_if_id, n_en_id_ex, n_en_ex_mem, n_en_mem_wb,
//  flush_if_id, flush_id_ex}.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] C_ADV = 7'b0000000;
    localparam logic [6:0] C_FRZ = 7'b1111100;
    localparam logic [6:0] C_BUB = 7'b0000011;
    localparam logic [6:0] C_LU  = 7'b1100001;

    typedef struct packed {
        logic [2:0] ctl;   // {mem_busy, ex_branch_taken, ex_mem_read}
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] use_; // {id_use_rs1, id_use_rs2}
        logic [8:0] exp;
    } vec_t;

    logic       clk;
    logic       n_reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
    logic [6:0] c3, c4;
    logic [1:0] st3, st4;

    int tests;
    int failed;
    logic [8:0] exp3_q[$];
    logic [8:0] exp4_q[$];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ps3, pf3, ps4, pf4;
`endif

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
        .clk             (clk),
        .n_reset         (n_reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .n_enable_pc     (c3[6]),
        .n_enable_if_id  (c3[5]),
        .n_enable_id_ex  (c3[4]),
        .n_enable_ex_mem (c3[3]),
        .n_enable_mem_wb (c3[2]),
        .flush_if_id     (c3[1]),
        .flush_id_ex     (c3[0]),
        .ctrl_state      (st3)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (ps3),
        .perf_flush_events (pf3)
`endif
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(32)) dut4 (
        .clk             (clk),
        .n_reset         (n_reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .n_enable_pc     (c4[6]),
        .n_enable_if_id  (c4[5]),
        .n_enable_id_ex  (c4[4]),
        .n_enable_ex_mem (c4[3]),
        .n_enable_mem_wb (c4[2]),
        .flush_if_id     (c4[1]),
        .flush_id_ex     (c4[0]),
        .ctrl_state      (st4)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (ps4),
        .perf_flush_events (pf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] ctl, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [1:0] use_, input logic [8:0] exp);
        vec_t v;
        v.ctl = ctl; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.use_ = use_; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        {mem_busy, ex_branch_taken, ex_mem_read} = v.ctl;
        ex_rd  = v.rd;
        id_rs1 = v.rs1;
        id_rs2 = v.rs2;
        {id_use_rs1, id_use_rs2} = v.use_;
    endtask

    function automatic logic [8:0] obs3();
        return {st3, c3};
    endfunction

    function automatic logic [8:0] obs4();
        return {st4, c4};
    endfunction

    task automatic test_reset();
        logic [8:0] got, exp;
        vec_t v[$];
        n_reset = 1'b0;
        v.push_back(mk(3'b110, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_FRZ}));
        v.push_back(mk(3'b001, 5'd5, 5'd5, 5'd0, 2'b10, {2'd0, C_FRZ}));
        foreach (v[i]) begin
            apply(v[i]);
            exp3_q.push_back(v[i].exp);
            exp4_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL reset3[%0d] got=%b expected=%b", i, got, exp); end
            got = obs4(); exp = exp4_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL reset4[%0d] got=%b expected=%b", i, got, exp); end
            @(posedge clk); #1;
        end
        n_reset = 1'b1;
        apply(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 9'd0));
    endtask

    task automatic test_load_use();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b001, 5'd5, 5'd5, 5'd0, 2'b10, {2'd0, C_LU}));
        v.push_back(mk(3'b000, 5'd5, 5'd5, 5'd0, 2'b10, {2'd0, C_ADV}));
        v.push_back(mk(3'b001, 5'd7, 5'd1, 5'd7, 2'b01, {2'd0, C_LU}));
        v.push_back(mk(3'b001, 5'd9, 5'd9, 5'd9, 2'b00, {2'd0, C_ADV}));
        v.push_back(mk(3'b001, 5'd9, 5'd8, 5'd9, 2'b10, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL load_use[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_x0();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b001, 5'd0, 5'd0, 5'd0, 2'b11, {2'd0, C_ADV}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL x0_no_hazard[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b001, 5'd4, 5'd4, 5'd0, 2'b10, {2'd0, C_LU}));
        v.push_back(mk(3'b001, 5'd6, 5'd0, 5'd6, 2'b01, {2'd0, C_LU}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL back_to_back[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_branch_flush();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL branch_flush[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_mem_wait_branch();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b110, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_FRZ}));
        v.push_back(mk(3'b110, 5'd0, 5'd0, 5'd0, 2'b00, {2'd1, C_FRZ}));
        v.push_back(mk(3'b110, 5'd0, 5'd0, 5'd0, 2'b00, {2'd1, C_FRZ}));
        v.push_back(mk(3'b110, 5'd0, 5'd0, 5'd0, 2'b00, {2'd1, C_FRZ}));
        v.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 2'b00, {2'd1, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL mem_wait_branch[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_branch_load_use();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b011, 5'd3, 5'd3, 5'd0, 2'b10, {2'd0, C_BUB}));
        v.push_back(mk(3'b001, 5'd3, 5'd3, 5'd0, 2'b10, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL branch_load_use[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_flush_freeze();
        logic [8:0] got, exp;
        vec_t v[$];
        v.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_BUB}));
        v.push_back(mk(3'b100, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_FRZ}));
        v.push_back(mk(3'b001, 5'd2, 5'd2, 5'd0, 2'b10, {2'd2, C_BUB}));
        v.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 2'b00, {2'd2, C_BUB}));
        v.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, {2'd0, C_ADV}));
        foreach (v[i]) begin
            @(posedge clk); #1;
            apply(v[i]); exp3_q.push_back(v[i].exp);
            @(negedge clk);
            got = obs3(); exp = exp3_q.pop_front(); tests++;
            if (got !== exp) begin failed++; $display("FAIL flush_freeze[%0d] got=%b expected=%b", i, got, exp); end
        end
    endtask

    task automatic test_flush_reset();
        logic [8:0] got, exp;
        vec_t idle;
        idle = mk(3'b000, 5'd0, 5'd0, 5'd0, 2'b00, 9'd0);
        repeat (4) begin
            @(posedge clk); #1;
            apply(idle);
        end
        @(posedge clk); #1;
        apply(mk(3'b010, 5'd0, 5'd0, 5'd0, 2'b00, 9'd0));
        exp4_q.push_back({2'd0, C_BUB});
        @(negedge clk);
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL flush4_start got=%b expected=%b", got, exp); end
        @(posedge clk); #1;
        apply(idle);
        exp4_q.push_back({2'd2, C_BUB});
        @(negedge clk);
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL flush4_second got=%b expected=%b", got, exp); end
        #2;
        n_reset = 1'b0;
        exp4_q.push_back({2'd0, C_FRZ});
        #1;
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL async_reset got=%b expected=%b", got, exp); end
        @(posedge clk); #1;
        exp4_q.push_back({2'd0, C_FRZ});
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL reset_held got=%b expected=%b", got, exp); end
        n_reset = 1'b1;
        exp4_q.push_back({2'd0, C_ADV});
        @(negedge clk);
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL post_release got=%b expected=%b", got, exp); end
        @(posedge clk); #1;
        apply(idle);
        exp4_q.push_back({2'd0, C_ADV});
        @(negedge clk);
        got = obs4(); exp = exp4_q.pop_front(); tests++;
        if (got !== exp) begin failed++; $display("FAIL no_pending_flush got=%b expected=%b", got, exp); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_load_use();
        test_x0();
        test_back_to_back();
        test_branch_flush();
        test_mem_wait_branch();
        test_branch_load_use();
        test_flush_freeze();
        test_flush_reset();
        if (exp3_q.size() != 0 || exp4_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp3_q.size() + exp4_q.size());
        end
        tests++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
